keypad_paddle_scanner: RTL and testbench

//  Scans the 4x4 keypad matrix and produces debounced paddle commands (up1/down1/up2/down2)

---
 rtl/keypad_paddle_scanner.sv | 85 ++++++++
 tb/tb_keypad_paddle_scanner.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_paddle_scanner.sv
// keypad_paddle_scanner: 4x4 keypad row scanner with per-key debounce producing paddle levels and a start pulse.
// Optional KP_CONFLICT_MASK_EN: a player's up/down outputs are both forced low while both keys are held.
module keypad_paddle_scanner #(
  parameter int SCAN_DIV = 12500,
  parameter int DEB_CNT  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] kp_col,
  output logic [3:0] kp_row,
  output logic       up1,
  output logic       down1,
  output logic       up2,
  output logic       down2,
  output logic       start_pulse
);
  localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_CNT);
  // key order (lsb first): up1, down1, up2, down2, start
  localparam logic [9:0] KROW = {2'd3, 2'd1, 2'd0, 2'd1, 2'd0};
  localparam logic [9:0] KCOL = {2'd1, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [DW-1:0] div_cnt;
  logic [1:0]    row_idx;
  logic          tick;
  logic [4:0]    deb;
  logic          deb_start_d;
  logic          unused_col;
  assign unused_col = kp_col[2];
  assign tick = div_cnt == DW'(SCAN_DIV - 1);
  // row slot divider; the row register moves to the next row on the sampling cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      div_cnt <= '0;
      row_idx <= '0;
      kp_row  <= 4'b1110;
    end else if (tick) begin
      div_cnt <= '0;
      row_idx <= row_idx + 2'd1;
      kp_row  <= ~(4'b0001 << (row_idx + 2'd1));
    end else
      div_cnt <= div_cnt + DW'(1);
  for (genvar k = 0; k < 5; k++) begin : g_key
    logic [CW-1:0] cnt;
    logic          state;
    logic          smp;
    logic          raw;
    assign smp    = tick && row_idx == KROW[2*k +: 2];
    assign raw    = ~kp_col[KCOL[2*k +: 2]];
    assign deb[k] = state;
    // flip the debounced state after DEB_CNT consecutive disagreeing frame samples
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        cnt   <= '0;
        state <= 1'b0;
      end else if (smp) begin
        if (raw == state)
          cnt <= '0;
        else if (cnt == CW'(DEB_CNT - 1)) begin
          state <= raw;
          cnt   <= '0;
        end else
          cnt <= cnt + CW'(1);
      end
  end
  // registered rising-edge detect of the debounced start key
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      deb_start_d <= 1'b0;
      start_pulse <= 1'b0;
    end else begin
      deb_start_d <= deb[4];
      start_pulse <= deb[4] & ~deb_start_d;
    end
`ifdef KP_CONFLICT_MASK_EN
  assign up1   = deb[0] & ~deb[1];
  assign down1 = deb[1] & ~deb[0];
  assign up2   = deb[2] & ~deb[3];
  assign down2 = deb[3] & ~deb[2];
`else
  assign up1   = deb[0];
  assign down1 = deb[1];
  assign up2   = deb[2];
  assign down2 = deb[3];
`endif
endmodule

// File: tb/tb_keypad_paddle_scanner.sv
// tb_keypad_paddle_scanner: randomized and directed checks of the keypad scanner against a frame-level model.
module tb_keypad_paddle_scanner;
  localparam int SD  = 4;
  localparam int DEB = 3;
  localparam int FR  = 4 * SD;
  localparam int KIDX [5] = '{0, 4, 3, 7, 13};
  logic       clk;
  logic       rst;
  logic [3:0] kp_col;
  logic [3:0] kp_row;
  logic       up1, down1, up2, down2, start_pulse;
  logic [15:0] pressed;
  logic [8:0]  obs;
  int          n_chk;
  int          n_fail;
  int          cyc;
  logic [4:0]  m_deb;
  int          m_run [5];
  logic        m_sp, m_dd;
  keypad_paddle_scanner #(.SCAN_DIV(SD), .DEB_CNT(DEB)) dut (
    .clk(clk), .rst(rst), .kp_col(kp_col), .kp_row(kp_row),
    .up1(up1), .down1(down1), .up2(up2), .down2(down2), .start_pulse(start_pulse)
  );
  assign obs = {kp_row, up1, down1, up2, down2, start_pulse};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // keypad matrix: a pressed key pulls its column low only while its row is driven
  always @* begin
    kp_col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!kp_row[r]) kp_col = kp_col & ~pressed[r*4 +: 4];
  end
  // frame-level reference: each key seen once per frame in its row slot
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc <= 0;
      m_deb <= '0;
      m_sp <= 1'b0;
      m_dd <= 1'b0;
      for (int k = 0; k < 5; k++) m_run[k] <= 0;
    end else begin
      cyc <= cyc + 1;
      m_dd <= m_deb[4];
      m_sp <= m_deb[4] & ~m_dd;
      if (cyc % SD == SD - 1)
        for (int k = 0; k < 5; k++)
          if (KIDX[k] / 4 == (cyc / SD) % 4) begin
            if (pressed[KIDX[k]] == m_deb[k]) m_run[k] <= 0;
            else if (m_run[k] + 1 == DEB) begin
              m_deb[k] <= pressed[KIDX[k]];
              m_run[k] <= 0;
            end else m_run[k] <= m_run[k] + 1;
          end
    end
  end
  function automatic logic [8:0] expv();
    logic u1, d1, u2, d2;
    u1 = m_deb[0]; d1 = m_deb[1]; u2 = m_deb[2]; d2 = m_deb[3];
`ifdef KP_CONFLICT_MASK_EN
    if (u1 && d1) begin u1 = 1'b0; d1 = 1'b0; end
    if (u2 && d2) begin u2 = 1'b0; d2 = 1'b0; end
`endif
    return {~(4'b0001 << ((cyc / SD) % 4)), u1, d1, u2, d2, m_sp};
  endfunction
  task automatic test_reset();
    pressed = '0;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_chk++;
      if (obs !== 9'b1110_00000) begin n_fail++; $display("FAIL reset_hold: got %b want %b", obs, 9'b1110_00000); end
    end
    rst = 1'b1;
    for (int i = 0; i < 3 * FR; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL row_scan cyc%0d: got %b want %b", i, obs, expv()); end
    end
  endtask
  task automatic test_press_release();
    pressed = 16'h0001;
    for (int i = 0; i < 5 * FR; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL press cyc%0d: got %b want %b", i, obs, expv()); end
    end
    n_chk++;
    if ({up1, down1} !== 2'b10) begin n_fail++; $display("FAIL press_level: got %b want 10", {up1, down1}); end
    pressed = '0;
    for (int i = 0; i < 5 * FR; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL release cyc%0d: got %b want %b", i, obs, expv()); end
    end
    n_chk++;
    if ({up1, down1} !== 2'b00) begin n_fail++; $display("FAIL release_level: got %b want 00", {up1, down1}); end
  endtask
  task automatic test_bounce();
    logic seen;
    seen = 1'b0;
    for (int f = 0; f < 10; f++) begin
      pressed = (f % 2 == 0) ? 16'h0001 : 16'h0000;
      for (int i = 0; i < FR; i++) begin
        @(negedge clk);
        seen = seen | up1;
        n_chk++;
        if (obs !== expv()) begin n_fail++; $display("FAIL bounce f%0d: got %b want %b", f, obs, expv()); end
      end
    end
    pressed = '0;
    n_chk++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL bounce_up1: got %b want 0", seen); end
  endtask
  task automatic test_start();
    int pulses;
    pulses = 0;
    pressed = 16'h2000;
    for (int i = 0; i < 11 * FR; i++) begin
      if (i == 6 * FR) pressed = '0;
      @(negedge clk);
      pulses += int'(start_pulse);
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL start cyc%0d: got %b want %b", i, obs, expv()); end
    end
    n_chk++;
    if (pulses !== 1) begin n_fail++; $display("FAIL start_count: got %0d want 1", pulses); end
  endtask
  task automatic test_conflict();
    pressed = 16'h0088;
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL conflict cyc%0d: got %b want %b", i, obs, expv()); end
    end
    n_chk++;
`ifdef KP_CONFLICT_MASK_EN
    if ({up2, down2} !== 2'b00) begin n_fail++; $display("FAIL conflict_level: got %b want 00", {up2, down2}); end
`else
    if ({up2, down2} !== 2'b11) begin n_fail++; $display("FAIL conflict_level: got %b want 11", {up2, down2}); end
`endif
    pressed = 16'h0008;
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL conflict_rel cyc%0d: got %b want %b", i, obs, expv()); end
    end
    n_chk++;
    if ({up2, down2} !== 2'b10) begin n_fail++; $display("FAIL conflict_rel_level: got %b want 10", {up2, down2}); end
    pressed = '0;
    repeat (4 * FR) @(negedge clk);
  endtask
  task automatic test_reset_mid();
    pressed = 16'h0001;
    repeat (2 * FR) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if (obs !== 9'b1110_00000) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs, 9'b1110_00000); end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4 * FR; i++) begin
      @(negedge clk);
      if (i == 2 * FR - 1) begin
        n_chk++;
        if (up1 !== 1'b0) begin n_fail++; $display("FAIL reset_restart_early: got %b want 0", up1); end
      end
      n_chk++;
      if (obs !== expv()) begin n_fail++; $display("FAIL reset_mid cyc%0d: got %b want %b", i, obs, expv()); end
    end
    n_chk++;
    if (up1 !== 1'b1) begin n_fail++; $display("FAIL reset_restart_late: got %b want 1", up1); end
  endtask
  task automatic test_random();
    int len;
    for (int s = 0; s < 30; s++) begin
      pressed = 16'($urandom);
      len = $urandom_range(1, 4) * FR + $urandom_range(0, FR - 1);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 63) == 0) pressed[KIDX[$urandom_range(0, 4)]] ^= 1'b1;
        @(negedge clk);
        n_chk++;
        if (obs !== expv()) begin n_fail++; $display("FAIL random s%0d cyc%0d: got %b want %b", s, i, obs, expv()); end
      end
    end
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    pressed = '0;
    rst = 1'b0;
    test_reset();
    test_press_release();
    test_bounce();
    test_start();
    test_conflict();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
